// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the branch resolver slice: branch-op / flag-select
// encoding, FSM state encoding and the comparator flag payload.
package branch_resolver_pkg;

   localparam int unsigned BR_OP_W = 2;
   localparam int unsigned ST_W    = 2;

   // Branch opcode; the same encoding drives the ALU flag-mux select.
   typedef enum logic [BR_OP_W-1:0] {
      BR_BLE = 2'b00,
      BR_BGT = 2'b01,
      BR_BEQ = 2'b10,
      BR_BNE = 2'b11
   } branch_op_e;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE    = 2'd0,
      ST_EVAL    = 2'd1,
      ST_RESOLVE = 2'd2
   } state_e;

   typedef struct packed {
      logic le;
      logic gt;
      logic eq;
      logic ne;
   } cmp_flags_t;

endpackage

// File: rtl/branch_resolver_if.sv
// Control/flag-mux/PC-write signal bundle around the branch resolver.
// BRANCH_STATS_EN adds the taken/not-taken statistics counters.
interface branch_resolver_if #(
   parameter int unsigned DATA_W = 32
`ifdef BRANCH_STATS_EN
   , parameter int unsigned STAT_W = 16
`endif
);
   import branch_resolver_pkg::*;

   logic                start;
   logic                flush;
   logic [BR_OP_W-1:0]  branch_op;
   logic [DATA_W-1:0]   op_a;
   logic [DATA_W-1:0]   op_b;
   logic                cond_in;
   logic [BR_OP_W-1:0]  alu_flag_sel;
   logic                flag_or;
   logic                flag_gt;
   logic                flag_zero;
   logic                flag_nzero;
   logic                busy;
   logic                pc_write;
   logic                done;
   logic                taken;
`ifdef BRANCH_STATS_EN
   logic [STAT_W-1:0]   stat_taken;
   logic [STAT_W-1:0]   stat_not_taken;
`endif

   // Control unit and flag mux side.
   modport master (
      output start, flush, branch_op, op_a, op_b, cond_in,
      input  alu_flag_sel, flag_or, flag_gt, flag_zero, flag_nzero,
      input  busy, pc_write, done, taken
`ifdef BRANCH_STATS_EN
      , input stat_taken, stat_not_taken
`endif
   );

   // Branch resolver side.
   modport slave (
      input  start, flush, branch_op, op_a, op_b, cond_in,
      output alu_flag_sel, flag_or, flag_gt, flag_zero, flag_nzero,
      output busy, pc_write, done, taken
`ifdef BRANCH_STATS_EN
      , output stat_taken, stat_not_taken
`endif
   );

endinterface

// File: rtl/branch_cmp.sv
// Purely combinational two's-complement comparator producing le/gt/eq/ne flags.
module branch_cmp
   import branch_resolver_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output cmp_flags_t        flags_c
);

   logic gt_c;
   logic eq_c;

   assign gt_c = $signed(a) > $signed(b);
   assign eq_c = (a == b);

   // le is the complement of gt, ne of eq: exactly one of each pair is set.
   always_comb begin
      flags_c    = '0;
      flags_c.gt = gt_c;
      flags_c.le = ~gt_c;
      flags_c.eq = eq_c;
      flags_c.ne = ~eq_c;
   end

endmodule

// File: rtl/branch_resolver.sv
// Multicycle branch sequencer (IDLE -> EVAL -> RESOLVE): drives flag select and compare
// flags, samples cond_in, pulses pc_write on taken. BRANCH_STATS_EN adds saturating counters.
module branch_resolver
   import branch_resolver_pkg::*;
#(
   parameter int unsigned DATA_W = 32
`ifdef BRANCH_STATS_EN
   , parameter int unsigned STAT_W = 16
`endif
) (
   input logic              clk,
   input logic              reset,
   branch_resolver_if.slave bus
);

   state_e            state;
   state_e            state_nxt;
   logic              accept_c;
   logic              busy_c;
   logic              done_c;
   logic              pc_write_c;

   branch_op_e        op_q;
   logic [DATA_W-1:0] op_a_q;
   logic [DATA_W-1:0] op_b_q;
   logic [DATA_W-1:0] cmp_a_c;
   logic [DATA_W-1:0] cmp_b_c;
   cmp_flags_t        cmp_flags_c;
   cmp_flags_t        flags_q;
   logic              taken_q;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state and per-state strobes; flush kills done/pc_write in the same cycle.
   always_comb begin
      state_nxt  = state;
      accept_c   = 1'b0;
      busy_c     = 1'b0;
      done_c     = 1'b0;
      pc_write_c = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start && !bus.flush) begin
               accept_c  = 1'b1;
               state_nxt = ST_EVAL;
            end
         end
         ST_EVAL: begin
            busy_c    = 1'b1;
            state_nxt = bus.flush ? ST_IDLE : ST_RESOLVE;
         end
         ST_RESOLVE: begin
            busy_c     = 1'b1;
            done_c     = !bus.flush;
            pc_write_c = !bus.flush && taken_q;
            state_nxt  = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // On accept compare the incoming operands; afterwards the latched copy feeds the comparator.
   assign cmp_a_c = accept_c ? bus.op_a : op_a_q;
   assign cmp_b_c = accept_c ? bus.op_b : op_b_q;

   branch_cmp #(
      .DATA_W (DATA_W)
   ) u_cmp (
      .a       (cmp_a_c),
      .b       (cmp_b_c),
      .flags_c (cmp_flags_c)
   );

   // Request registers, compare flags and the resolved outcome.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q    <= BR_BLE;
         op_a_q  <= '0;
         op_b_q  <= '0;
         flags_q <= '0;
         taken_q <= 1'b0;
      end else begin
         if (accept_c) begin
            op_q   <= branch_op_e'(bus.branch_op);
            op_a_q <= bus.op_a;
            op_b_q <= bus.op_b;
         end
         if (accept_c || state == ST_EVAL) flags_q <= cmp_flags_c;
         if (state == ST_EVAL && !bus.flush) taken_q <= bus.cond_in;
      end
   end

   assign bus.alu_flag_sel = op_q;
   assign bus.flag_or      = flags_q.le;
   assign bus.flag_gt      = flags_q.gt;
   assign bus.flag_zero    = flags_q.eq;
   assign bus.flag_nzero   = flags_q.ne;
   assign bus.busy         = busy_c;
   assign bus.done         = done_c;
   assign bus.pc_write     = pc_write_c;
   assign bus.taken        = taken_q;

`ifdef BRANCH_STATS_EN
   logic [STAT_W-1:0] stat_taken_q;
   logic [STAT_W-1:0] stat_not_taken_q;

   // Exactly one saturating counter steps per completed (non-flushed) resolution.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_taken_q     <= '0;
         stat_not_taken_q <= '0;
      end else if (done_c) begin
         if (taken_q) begin
            if (stat_taken_q != '1) stat_taken_q <= stat_taken_q + STAT_W'(1);
         end else begin
            if (stat_not_taken_q != '1) stat_not_taken_q <= stat_not_taken_q + STAT_W'(1);
         end
      end
   end

   assign bus.stat_taken     = stat_taken_q;
   assign bus.stat_not_taken = stat_not_taken_q;
`endif

   // Flags always hold a complementary pair once a request has been accepted.
   a_flags_pair: assert property (@(posedge clk) disable iff (reset)
      (state != ST_IDLE) |-> ((flags_q.eq != flags_q.ne) && (flags_q.le != flags_q.gt)));

   a_pc_write_done: assert property (@(posedge clk) disable iff (reset)
      pc_write_c |-> done_c);

endmodule
